// File: rtl/exec_issue.sv
// exec_issue: two-entry RV32I issue/execute stage.
//   p0 = combinational decode of the offered instruction,
//   p1 = S1, decoded operands presented to the arithmetic unit,
//   p2 = S2, writeback payload offered downstream.
// Optional feature: define EXEC_ISSUE_BYPASS_EN to forward in-flight
// S1/S2 results into the rs1/rs2 operands of the instruction being decoded.
module exec_issue #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [DATA_WIDTH-1:0] in_rs1_val,
   input  logic [DATA_WIDTH-1:0] in_rs2_val,
   output logic [DATA_WIDTH-1:0] alu_lhs,
   output logic [DATA_WIDTH-1:0] alu_rhs,
   output logic [2:0]            alu_operation,
   output logic [6:0]            alu_metadata,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_valid,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4:0]            out_rd,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_illegal
);

   localparam int SHW = $clog2(DATA_WIDTH);
   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [DATA_WIDTH-1:0] SHAMT_MASK = DATA_WIDTH'((1 << SHW) - 1);

   // Sign-extend a 12-bit I-type immediate to the datapath width.
   function automatic logic [DATA_WIDTH-1:0] sext_imm(input logic signed [11:0] imm);
      return DATA_WIDTH'(imm);
   endfunction

   // Keep only the shift-amount bits of an operand (shifts ignore the rest).
   function automatic logic [DATA_WIDTH-1:0] mask_shamt(input logic [DATA_WIDTH-1:0] v);
      return v & SHAMT_MASK;
   endfunction

   // Illegal results are forced to zero so no garbage reaches writeback.
   function automatic logic [DATA_WIDTH-1:0] gate_result(input logic ill,
                                                         input logic [DATA_WIDTH-1:0] r);
      return ill ? '0 : r;
   endfunction

   // S1 registers
   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] lhs_p1;
   logic [DATA_WIDTH-1:0] rhs_p1;
   logic [2:0]            op_p1;
   logic [6:0]            meta_p1;
   logic [4:0]            rd_p1;
   logic                  bad_p1;

   // S2 registers
   logic                  vld_p2;
   logic [4:0]            rd_p2;
   logic [DATA_WIDTH-1:0] result_p2;
   logic                  illegal_p2;

   // decode signals
   logic [6:0]            opcode_p0;
   logic [2:0]            op_p0;
   logic                  is_shift_p0;
   logic [DATA_WIDTH-1:0] rs1_val_p0;
   logic [DATA_WIDTH-1:0] rs2_val_p0;
   logic [DATA_WIDTH-1:0] lhs_p0;
   logic [DATA_WIDTH-1:0] rhs_p0;
   logic [6:0]            meta_p0;
   logic                  bad_p0;

   // handshake signals
   logic                  s2_free;
   logic                  move_p1;
   logic                  accept;
   logic                  illegal_p1;

   assign opcode_p0   = in_instr[6:0];
   assign op_p0       = in_instr[14:12];
   assign is_shift_p0 = (op_p0 == 3'd1) || (op_p0 == 3'd5);

`ifdef EXEC_ISSUE_BYPASS_EN
   logic [4:0] src1_p0;
   logic [4:0] src2_p0;
   logic       fwd_p1;
   logic       fwd_p2;

   assign src1_p0 = in_instr[19:15];
   assign src2_p0 = in_instr[24:20];
   // Only entries that will really write a register may forward; S1 is
   // legal only if its opcode is good and the unit reports a valid result.
   assign fwd_p1  = vld_p1 && !bad_p1 && alu_valid && (rd_p1 != 5'd0);
   assign fwd_p2  = vld_p2 && !illegal_p2 && (rd_p2 != 5'd0);

   // Operand forwarding: S1 is younger than S2, so it wins on a double match.
   always_comb begin
      rs1_val_p0 = in_rs1_val;
      rs2_val_p0 = in_rs2_val;
      if (fwd_p1 && (rd_p1 == src1_p0)) begin
         rs1_val_p0 = alu_result;
      end else if (fwd_p2 && (rd_p2 == src1_p0)) begin
         rs1_val_p0 = result_p2;
      end
      if (opcode_p0 == OPC_OP) begin
         if (fwd_p1 && (rd_p1 == src2_p0)) begin
            rs2_val_p0 = alu_result;
         end else if (fwd_p2 && (rd_p2 == src2_p0)) begin
            rs2_val_p0 = result_p2;
         end
      end
   end
`else
   logic unused_rs1_field;

   assign rs1_val_p0       = in_rs1_val;
   assign rs2_val_p0       = in_rs2_val;
   assign unused_rs1_field = ^in_instr[19:15];
`endif

   // p0 decode: choose rhs and metadata from the opcode class.
   always_comb begin
      lhs_p0  = rs1_val_p0;
      rhs_p0  = rs2_val_p0;
      meta_p0 = 7'd0;
      bad_p0  = 1'b0;
      if (opcode_p0 == OPC_OP) begin
         meta_p0 = in_instr[31:25];
      end else if (opcode_p0 == OPC_IMM) begin
         rhs_p0 = sext_imm(in_instr[31:20]);
         if (is_shift_p0) begin
            meta_p0 = in_instr[31:25];
         end
      end else begin
         bad_p0 = 1'b1;
      end
      if (is_shift_p0) begin
         rhs_p0 = mask_shamt(rhs_p0);
      end
   end

   assign s2_free    = !vld_p2 || out_ready;
   assign move_p1    = vld_p1 && s2_free;
   assign in_ready   = !vld_p1 || move_p1;
   assign accept     = in_valid && in_ready;
   assign illegal_p1 = bad_p1 || !alu_valid;

   // p0 -> p1 boundary: capture decoded operands on accept, empty on move-out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         lhs_p1  <= '0;
         rhs_p1  <= '0;
         op_p1   <= 3'd0;
         meta_p1 <= 7'd0;
         rd_p1   <= 5'd0;
         bad_p1  <= 1'b0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         lhs_p1  <= lhs_p0;
         rhs_p1  <= rhs_p0;
         op_p1   <= op_p0;
         meta_p1 <= meta_p0;
         rd_p1   <= in_instr[11:7];
         bad_p1  <= bad_p0;
      end else if (move_p1) begin
         vld_p1  <= 1'b0;
      end
   end

   // p1 -> p2 boundary: load result whenever S2 is free; hold while blocked.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p2     <= 1'b0;
         rd_p2      <= 5'd0;
         result_p2  <= '0;
         illegal_p2 <= 1'b0;
      end else if (s2_free) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            rd_p2      <= rd_p1;
            result_p2  <= gate_result(illegal_p1, alu_result);
            illegal_p2 <= illegal_p1;
         end
      end
   end

   assign alu_lhs       = lhs_p1;
   assign alu_rhs       = rhs_p1;
   assign alu_operation = op_p1;
   assign alu_metadata  = meta_p1;

   assign out_valid   = vld_p2;
   assign out_rd      = rd_p2;
   assign out_result  = result_p2;
   assign out_illegal = illegal_p2;

endmodule

// File: tb/tb_exec_issue.sv
// Self-checking bench for exec_issue: directed scenarios plus a randomized
// run against an architectural RV32I reference model.
module tb_exec_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs1_val;
   logic [31:0] in_rs2_val;
   logic [31:0] alu_lhs;
   logic [31:0] alu_rhs;
   logic [2:0]  alu_operation;
   logic [6:0]  alu_metadata;
   logic [31:0] alu_result;
   logic        alu_valid;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd;
   logic [31:0] out_result;
   logic        out_illegal;
   logic        alu_ok;

   int vectors = 0;
   int miscompares = 0;

   exec_issue #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_operation(alu_operation),
      .alu_metadata(alu_metadata), .alu_result(alu_result), .alu_valid(alu_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_result(out_result), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   // Arithmetic unit attached to the stage (environment, not the reference).
   always_comb begin
      alu_valid  = alu_ok;
      alu_result = 32'd0;
      case (alu_operation)
         3'd0: alu_result = alu_metadata[5] ? alu_lhs - alu_rhs : alu_lhs + alu_rhs;
         3'd1: alu_result = alu_lhs << alu_rhs[4:0];
         3'd2: alu_result = ($signed(alu_lhs) < $signed(alu_rhs)) ? 32'd1 : 32'd0;
         3'd3: alu_result = (alu_lhs < alu_rhs) ? 32'd1 : 32'd0;
         3'd4: alu_result = alu_lhs ^ alu_rhs;
         3'd5: begin
            if (alu_metadata[5]) alu_result = $signed(alu_lhs) >>> alu_rhs[4:0];
            else                 alu_result = alu_lhs >> alu_rhs[4:0];
         end
         3'd6: alu_result = alu_lhs | alu_rhs;
         default: alu_result = alu_lhs & alu_rhs;
      endcase
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   // Architectural meaning of one instruction: {illegal, rd, result}.
   function automatic logic [37:0] ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [6:0]  opc;
      logic [31:0] y;
      logic [31:0] r;
      logic [4:0]  sh;
      logic        is_op;
      opc   = ins[6:0];
      is_op = (opc == 7'b0110011);
      if (!is_op && opc != 7'b0010011) return {1'b1, ins[11:7], 32'd0};
      y  = is_op ? b : {{20{ins[31]}}, ins[31:20]};
      sh = is_op ? b[4:0] : ins[24:20];
      case (ins[14:12])
         3'd0: r = (is_op && ins[30]) ? a - y : a + y;
         3'd1: r = a << sh;
         3'd2: r = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
         3'd3: r = (a < y) ? 32'd1 : 32'd0;
         3'd4: r = a ^ y;
         3'd5: begin
            if (ins[30]) r = $signed(a) >>> sh;
            else         r = a >> sh;
         end
         3'd6: r = a | y;
         default: r = a & y;
      endcase
      return {1'b0, ins[11:7], r};
   endfunction

   function automatic logic [31:0] gen_instr();
      int          k;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [31:0] rnd;
      logic [6:0]  opc;
      k   = $urandom_range(0, 9);
      rd  = 5'($urandom_range(0, 5));
      rs1 = 5'($urandom_range(0, 5));
      rs2 = 5'($urandom_range(0, 5));
      f3  = 3'($urandom_range(0, 7));
      rnd = $urandom;
      if (k < 5) return enc_r(rnd[20] ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      if (k < 9) begin
         imm = rnd[11:0];
         if (f3 == 3'd1)      imm[11:5] = 7'h00;
         else if (f3 == 3'd5) imm[11:5] = rnd[12] ? 7'h20 : 7'h00;
         return enc_i(imm, rs1, f3, rd);
      end
      case (rnd[14:13])
         2'd0:    opc = 7'b0000011;
         2'd1:    opc = 7'b0100011;
         2'd2:    opc = 7'b1100011;
         default: opc = 7'b1101111;
      endcase
      return {rnd[31:7], opc};
   endfunction

   task automatic idle_inputs();
      in_valid   = 1'b0;
      in_instr   = 32'd0;
      in_rs1_val = 32'd0;
      in_rs2_val = 32'd0;
      out_ready  = 1'b1;
      alu_ok     = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: observed %b expected 0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: observed %b expected 1", in_ready); end
      vectors++; if (out_rd !== 5'd0) begin miscompares++; $display("FAIL rst_out_rd: observed %h expected 0", out_rd); end
      vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL rst_out_result: observed %h expected 0", out_result); end
      vectors++; if (out_illegal !== 1'b0) begin miscompares++; $display("FAIL rst_out_illegal: observed %b expected 0", out_illegal); end
      vectors++; if (alu_lhs !== 32'd0 || alu_rhs !== 32'd0) begin miscompares++; $display("FAIL rst_alu_ops: observed %h/%h expected 0/0", alu_lhs, alu_rhs); end
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release: observed %b/%b expected 0/1", out_valid, in_ready); end
   endtask

   task automatic test_add();
      in_valid = 1'b1; in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
      in_rs1_val = 32'd5; in_rs2_val = 32'd7;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL add_in_ready: observed %b expected 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_early_valid: observed %b expected 0", out_valid); end
      vectors++; if (alu_lhs !== 32'd5 || alu_rhs !== 32'd7) begin miscompares++; $display("FAIL add_alu_ops: observed %h/%h expected 5/7", alu_lhs, alu_rhs); end
      vectors++; if (alu_operation !== 3'd0 || alu_metadata !== 7'd0) begin miscompares++; $display("FAIL add_alu_ctl: observed %h/%h expected 0/0", alu_operation, alu_metadata); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_out_valid: observed %b expected 1", out_valid); end
      vectors++; if ({out_illegal, out_rd, out_result} !== {1'b0, 5'd3, 32'd12}) begin miscompares++; $display("FAIL add_payload: observed %b/%0d/%h expected 0/3/0000000c", out_illegal, out_rd, out_result); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain: observed %b expected 0", out_valid); end
   endtask

   task automatic test_srai();
      in_valid = 1'b1; in_instr = enc_i(12'h403, 5'd1, 3'd5, 5'd4);
      in_rs1_val = 32'hFFFF_FFF0; in_rs2_val = 32'h1234_5678;
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if (alu_metadata !== 7'h20) begin miscompares++; $display("FAIL srai_meta: observed %h expected 20", alu_metadata); end
      vectors++; if (alu_rhs !== 32'd3) begin miscompares++; $display("FAIL srai_rhs: observed %h expected 3", alu_rhs); end
      vectors++; if (alu_operation !== 3'd5) begin miscompares++; $display("FAIL srai_op: observed %h expected 5", alu_operation); end
      @(negedge clk);
      vectors++; if ({out_valid, out_illegal, out_rd, out_result} !== {1'b1, 1'b0, 5'd4, 32'hFFFF_FFFE}) begin miscompares++; $display("FAIL srai_result: observed %b/%b/%0d/%h expected 1/0/4/fffffffe", out_valid, out_illegal, out_rd, out_result); end
      @(negedge clk);
   endtask

   task automatic test_addi_illegal();
      in_valid = 1'b1; in_instr = enc_i(12'hFFF, 5'd0, 3'd0, 5'd5);
      in_rs1_val = 32'd0; in_rs2_val = 32'hDEAD_BEEF;
      @(negedge clk);
      vectors++; if (alu_rhs !== 32'hFFFF_FFFF || alu_metadata !== 7'd0) begin miscompares++; $display("FAIL addi_dec: observed %h/%h expected ffffffff/0", alu_rhs, alu_metadata); end
      in_instr = {12'h004, 5'd1, 3'b010, 5'd6, 7'b0000011};
      in_rs1_val = 32'h0000_1000;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_in_ready: observed %b expected 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if ({out_valid, out_illegal, out_rd, out_result} !== {1'b1, 1'b0, 5'd5, 32'hFFFF_FFFF}) begin miscompares++; $display("FAIL addi_result: observed %b/%b/%0d/%h expected 1/0/5/ffffffff", out_valid, out_illegal, out_rd, out_result); end
      @(negedge clk);
      vectors++; if ({out_valid, out_illegal, out_rd, out_result} !== {1'b1, 1'b1, 5'd6, 32'd0}) begin miscompares++; $display("FAIL illegal_result: observed %b/%b/%0d/%h expected 1/1/6/0", out_valid, out_illegal, out_rd, out_result); end
      @(negedge clk);
   endtask

   task automatic test_alu_invalid();
      alu_ok = 1'b0;
      in_valid = 1'b1; in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7);
      in_rs1_val = 32'd1; in_rs2_val = 32'd2;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      vectors++; if ({out_valid, out_illegal, out_rd, out_result} !== {1'b1, 1'b1, 5'd7, 32'd0}) begin miscompares++; $display("FAIL alu_invalid: observed %b/%b/%0d/%h expected 1/1/7/0", out_valid, out_illegal, out_rd, out_result); end
      alu_ok = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] prog [4];
      logic [37:0] expv [4];
      logic [37:0] held;
      logic [37:0] got;
      int issued;
      int ndone;
      int cyc;
      bit blocked;
      for (int i = 0; i < 4; i++) begin
         prog[i] = enc_i(12'(3 * (i + 1)), 5'd0, 3'd0, 5'(8 + i));
         expv[i] = {1'b0, 5'(8 + i), 32'(3 * (i + 1))};
      end
      issued = 0; ndone = 0; cyc = 0; blocked = 0; held = '0;
      in_rs1_val = 32'd0; in_rs2_val = 32'd0;
      while (ndone < 4 && cyc < 40) begin
         out_ready = (cyc >= 3);
         in_valid  = (issued < 4);
         in_instr  = prog[issued < 4 ? issued : 3];
         #1;
         got = {out_illegal, out_rd, out_result};
         if (cyc == 2) begin
            vectors++; if (in_ready !== 1'b0 || issued != 2) begin miscompares++; $display("FAIL b2b_in_ready: observed %b after %0d accepts expected 0 after 2", in_ready, issued); end
         end
         if (blocked) begin
            vectors++; if (out_valid !== 1'b1 || got !== held) begin miscompares++; $display("FAIL b2b_hold: observed %b/%h expected 1/%h", out_valid, got, held); end
         end
         if (out_valid === 1'b1 && out_ready) begin
            vectors++; if (got !== expv[ndone]) begin miscompares++; $display("FAIL b2b_order: observed %h expected %h", got, expv[ndone]); end
            ndone++;
         end
         blocked = (out_valid === 1'b1) && !out_ready;
         held = got;
         if (in_valid && in_ready === 1'b1) issued++;
         @(negedge clk);
         cyc++;
      end
      vectors++; if (ndone != 4) begin miscompares++; $display("FAIL b2b_count: observed %0d expected 4", ndone); end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_bypass();
      logic [31:0] exp2;
`ifdef EXEC_ISSUE_BYPASS_EN
      exp2 = 32'd18;
`else
      exp2 = 32'd0;
`endif
      in_valid = 1'b1; in_instr = enc_i(12'd9, 5'd0, 3'd0, 5'd1);
      in_rs1_val = 32'd0; in_rs2_val = 32'd0;
      @(negedge clk);
      in_instr = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL byp_in_ready: observed %b expected 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if ({out_valid, out_illegal, out_rd, out_result} !== {1'b1, 1'b0, 5'd1, 32'd9}) begin miscompares++; $display("FAIL byp_first: observed %b/%b/%0d/%h expected 1/0/1/9", out_valid, out_illegal, out_rd, out_result); end
      @(negedge clk);
      vectors++; if ({out_valid, out_illegal, out_rd, out_result} !== {1'b1, 1'b0, 5'd2, exp2}) begin miscompares++; $display("FAIL byp_second: observed %b/%b/%0d/%h expected 1/0/2/%h", out_valid, out_illegal, out_rd, out_result, exp2); end
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd3);
      @(negedge clk);
      in_instr = enc_i(12'd2, 5'd0, 3'd0, 5'd4);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_full: observed %b/%b expected 1/0", out_valid, in_ready); end
      rst = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset: observed %b/%b expected 0/1", out_valid, in_ready); end
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_ghost: observed %b expected 0 (cycle %0d)", out_valid, i); end
      end
   endtask

   task automatic test_random();
      logic [31:0] arch [32];
      logic [31:0] comm [32];
      logic [37:0] exp_q [$];
      logic [37:0] e;
      logic [37:0] held;
      logic [37:0] got;
      logic [31:0] ins;
      logic [31:0] a;
      logic [31:0] b;
      bit blocked;
      int cyc;
      for (int i = 0; i < 32; i++) begin arch[i] = 32'd0; comm[i] = 32'd0; end
      blocked = 0; cyc = 0; held = '0;
      while (cyc < 600 && (cyc < 400 || exp_q.size() != 0)) begin
         out_ready = ($urandom_range(0, 3) != 0) || (cyc >= 400);
         got = {out_illegal, out_rd, out_result};
         if (blocked) begin
            vectors++; if (out_valid !== 1'b1 || got !== held) begin miscompares++; $display("FAIL rnd_hold: observed %b/%h expected 1/%h", out_valid, got, held); end
         end
         if (out_valid === 1'b1 && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++; $display("FAIL rnd_spurious: observed %h expected nothing", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin miscompares++; $display("FAIL rnd_result: observed %h expected %h", got, e); end
               if (!e[37] && e[36:32] != 5'd0) comm[e[36:32]] = e[31:0];
            end
         end
         blocked = (out_valid === 1'b1) && !out_ready;
         held = got;
         ins = gen_instr();
         in_valid   = (cyc < 400) && ($urandom_range(0, 3) != 0);
         in_instr   = ins;
         in_rs1_val = comm[ins[19:15]];
         in_rs2_val = comm[ins[24:20]];
         #1;
         if (in_valid && in_ready === 1'b1) begin
`ifdef EXEC_ISSUE_BYPASS_EN
            a = arch[ins[19:15]];
            b = arch[ins[24:20]];
`else
            a = in_rs1_val;
            b = in_rs2_val;
`endif
            e = ref_exec(ins, a, b);
            exp_q.push_back(e);
            if (!e[37] && e[36:32] != 5'd0) arch[e[36:32]] = e[31:0];
         end
         @(negedge clk);
         cyc++;
      end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rnd_drain: observed %0d pending expected 0", exp_q.size()); end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_add();
      test_srai();
      test_addi_illegal();
      test_alu_invalid();
      test_back_to_back();
      test_bypass();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/exec_issue.md
EXEC_ISSUE -- requirements
Module: exec_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand/result width in bits.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  in  1  upstream offers an instruction.
REQ-005 SHALL have port in_ready  out  1  stage accepts the offer this cycle.
REQ-006 SHALL have port in_instr  in  32  RV32I instruction word.
REQ-007 SHALL have ports in_rs1_val, in_rs2_val  in  DATA_WIDTH  register-file read values for rs1 and rs2.
REQ-008 SHALL have ports alu_lhs, alu_rhs  out  DATA_WIDTH  operands to the arithmetic unit.
REQ-009 SHALL have ports alu_operation  out  3  (funct3) and alu_metadata  out  7  (funct7 / imm[11:5] / zero).
REQ-010 SHALL have ports alu_result  in  DATA_WIDTH and alu_valid  in  1  combinational reply from the arithmetic unit.
REQ-011 SHALL have ports out_valid  out  1, out_ready  in  1  downstream handshake.
REQ-012 SHALL have ports out_rd  out  5, out_result  out  DATA_WIDTH, out_illegal  out  1  writeback payload.

Function
REQ-013 SHALL be a 2-entry pipeline: S1 (decoded operands) and S2 (result); a transfer occurs on any edge where valid and ready are both 1.
REQ-014 SHALL decode combinationally from in_instr: opcode 0110011 (OP) -> rhs = rs2 value, metadata = instr[31:25]; opcode 0010011 (OP-IMM) -> rhs = sign-extended instr[31:20].
REQ-015 SHALL, for OP-IMM, set metadata = instr[31:25] when funct3 is 1 or 5 and metadata = 0 otherwise.
REQ-016 SHALL, for funct3 1 or 5 (both opcodes), zero-extend only the low log2(DATA_WIDTH) bits of rhs.
REQ-017 SHALL capture into S1 on accept: lhs, rhs, funct3, metadata, rd = instr[11:7], and a bad-opcode flag (opcode neither OP nor OP-IMM).
REQ-018 SHALL drive the alu_* outputs directly from S1 registers, with no combinational path from the in_* ports.
REQ-019 SHALL move S1 into S2 capturing alu_result, rd, and illegal = bad-opcode OR NOT alu_valid; out_result SHALL be 0 when illegal.
REQ-020 SHALL drive out_valid, out_rd, out_result and out_illegal only from S2 registers.
REQ-021 SHALL advance S2 when S2 is empty or out_ready=1; S1 advances when S1 is empty or S1->S2 moves; in_ready = S1 empty OR S1 moving.
REQ-022 SHALL sustain 1 instruction/cycle with out_ready held at 1; latency is accept edge N -> out_valid=1 after edge N+1.
REQ-023 SHALL hold S2 payload stable while out_valid=1 and out_ready=0, and hold S1 while blocked.
REQ-024 SHALL, on simultaneous S2 drain and S1->S2 move, load S2 with the new result without a bubble.
REQ-025 SHALL pass illegal instructions through the handshake like legal ones (no stall, no drop).

Reset
REQ-026 SHALL, while rst=0, clear the S1 and S2 valid bits immediately (out_valid=0, in_ready=1 after release); payload registers clear to 0.
REQ-027 SHALL discard in-flight S1/S2 contents when reset is asserted mid-operation; nothing SHALL be emitted for them after release.

Configuration
REQ-028 SHALL, with EXEC_ISSUE_BYPASS_EN defined, replace each source operand (rs1 = instr[19:15], rs2 = instr[24:20]) with a bypass value when a valid, non-illegal S1 or S2 entry has a matching nonzero rd.
REQ-029 SHALL, under EXEC_ISSUE_BYPASS_EN, take the bypass value from S1 (alu_result) in preference to S2 (out_result), and bypass rs2 only for OP.
REQ-030 SHALL, without EXEC_ISSUE_BYPASS_EN, use in_rs1_val/in_rs2_val unmodified and contain no comparison logic.

Verification
REQ-031 SHALL cover: ADD x3,x1,x2 with rs1=5, rs2=7, ALU model attached -> out_rd=3, out_result=12, out_illegal=0 one edge after acceptance.
REQ-032 SHALL cover: SRAI x4,x1,3 with rs1=0xFFFFFFF0 -> alu_metadata=0x20, alu_rhs=3, out_result=0xFFFFFFFE.
REQ-033 SHALL cover: ADDI x5,x0,-1 -> alu_rhs=0xFFFFFFFF, alu_metadata=0; opcode 0000011 -> out_illegal=1, out_result=0.
REQ-034 SHALL cover: 4 back-to-back instructions with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, payload stable, all 4 delivered in order, none lost.
REQ-035 SHALL cover: with macro defined, ADDI x1,x0,9 then ADD x2,x1,x1 with stale rs1=rs2=0 -> out_result=18; macro undefined -> 0.
REQ-036 SHALL cover: rst=0 asserted with both stages full -> out_valid=0 at once; no output after release.
